// File: rtl/fb_pkg.sv
// Shared types and constants for the frame-buffer scanout engine.
// The colour-bar generator is built only when FB_SCANOUT_TEST_PATTERN_EN is defined.
package fb_pkg;

  localparam int PIX_W = 15;
  typedef logic [PIX_W-1:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } scan_state_t;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int FRAME_PIXELS = H_ACTIVE_DEF * V_ACTIVE_DEF;

  // RGB555 colour bars, R in [14:10], G in [9:5], B in [4:0]
  localparam pixel_t BAR_WHITE   = 15'h7FFF;
  localparam pixel_t BAR_YELLOW  = 15'h7FE0;
  localparam pixel_t BAR_CYAN    = 15'h03FF;
  localparam pixel_t BAR_GREEN   = 15'h03E0;
  localparam pixel_t BAR_MAGENTA = 15'h7C1F;
  localparam pixel_t BAR_RED     = 15'h7C00;
  localparam pixel_t BAR_BLUE    = 15'h001F;
  localparam pixel_t BAR_BLACK   = 15'h0000;

  function automatic int frame_pixels(input int h, input int v);
    return h * v;
  endfunction

  // Counter width that still works for a dimension of 1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic pixel_t bar_color(input logic [2:0] idx);
    pixel_t c;
    case (idx)
      3'd0:    c = BAR_WHITE;
      3'd1:    c = BAR_YELLOW;
      3'd2:    c = BAR_CYAN;
      3'd3:    c = BAR_GREEN;
      3'd4:    c = BAR_MAGENTA;
      3'd5:    c = BAR_RED;
      3'd6:    c = BAR_BLUE;
      default: c = BAR_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/fb_out_fifo.sv
// Two-entry output buffer between the RAM read return and the pixel stream.
// Push and pop may happen in the same cycle; a push into a full buffer
// without a pop is dropped (the read-issue rule never lets that happen).
module fb_out_fifo #(
  parameter int DATA_WIDTH = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [1:0]            count,
  output logic [DATA_WIDTH-1:0] head
);

  logic [DATA_WIDTH-1:0] mem [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);
  assign head    = mem[rd_ptr];

  // Storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + 2'(do_push) - 2'(do_pop);
    end
  end

endmodule

// File: rtl/fb_scanout.sv
// Frame-buffer scanout: raster-order RAM reads into a valid/ready pixel stream
// with start-of-frame / end-of-line markers and a frame_done pulse.
// Optional feature macro: FB_SCANOUT_TEST_PATTERN_EN (internal colour bars).
//
// state | meaning
// IDLE  | no reads, waiting for en
// RUN   | issuing reads whenever buffer + in-flight leaves room
// DRAIN | frame's last read issued with en low; emptying buffer
module fb_scanout
  import fb_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 20,
  parameter int DATA_WIDTH    = 15,
  parameter int H_ACTIVE      = 640,
  parameter int V_ACTIVE      = 480
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     test_mode,
  output logic                     READ_EN,
  output logic [ADDRESS_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0]    rd_data,
  output logic [DATA_WIDTH-1:0]    m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     m_sof,
  output logic                     m_eol,
  output logic                     frame_done
);

  localparam int FRAME_PX = frame_pixels(H_ACTIVE, V_ACTIVE);
  localparam int XW       = cnt_width(H_ACTIVE);
  localparam int YW       = cnt_width(V_ACTIVE);

  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(FRAME_PX - 1);
  localparam logic [XW-1:0]            X_LAST    = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0]            Y_LAST    = YW'(V_ACTIVE - 1);

  scan_state_t               state_q;
  scan_state_t               state_d;
  logic [ADDRESS_WIDTH-1:0]  rd_addr_q;
  logic                      inflight_q;
  logic                      issue;
  logic                      pop;
  logic [XW-1:0]             x_q;
  logic [YW-1:0]             y_q;
  logic [1:0]                fifo_count;
  logic [DATA_WIDTH-1:0]     fifo_head;
  logic [DATA_WIDTH-1:0]     push_data;
  logic [2:0]                occupancy;
  logic                      last_addr;

  assign m_valid   = (fifo_count != 2'd0);
  assign pop       = m_valid && m_ready;
  assign occupancy = 3'(fifo_count) + 3'(inflight_q);
  assign last_addr = (rd_addr_q == LAST_ADDR);
  assign rd_addr   = rd_addr_q;

  // Next-state and read-issue decision.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) state_d = RUN;
      end
      RUN: begin
        issue = (occupancy < (3'd2 + 3'(pop)));
        if (issue && last_addr && !en) state_d = DRAIN;
      end
      DRAIN: begin
        if (!inflight_q && (fifo_count == 2'd0)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Read address (wraps at frame end) and in-flight tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_addr_q  <= '0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (issue) rd_addr_q <= last_addr ? '0 : rd_addr_q + 1'b1;
    end
  end

`ifdef FB_SCANOUT_TEST_PATTERN_EN
  localparam int BAR_W = (H_ACTIVE >= 8) ? (H_ACTIVE / 8) : 1;

  logic                  tp_q;
  logic                  tp_now;
  logic                  tp_inflight_q;
  logic [DATA_WIDTH-1:0] tp_pix_q;
  logic [XW-1:0]         rd_x_q;
  logic [2:0]            bar_idx;

  // test_mode only takes effect on the read of address 0.
  assign tp_now    = (rd_addr_q == '0) ? test_mode : tp_q;
  assign READ_EN   = issue && !tp_now;
  assign push_data = tp_inflight_q ? tp_pix_q : rd_data;

  // Bar index from the read-side column, last bar absorbs any remainder.
  always_comb begin
    bar_idx = 3'd7;
    if ((32'(rd_x_q) / BAR_W) < 8) bar_idx = 3'(32'(rd_x_q) / BAR_W);
  end

  // Generated pixel follows the same one-cycle path as a RAM read.
  always_ff @(posedge clk) begin
    if (rst) begin
      tp_q          <= 1'b0;
      tp_inflight_q <= 1'b0;
      tp_pix_q      <= '0;
      rd_x_q        <= '0;
    end else begin
      tp_inflight_q <= issue && tp_now;
      if (issue) begin
        tp_q     <= tp_now;
        tp_pix_q <= DATA_WIDTH'(bar_color(bar_idx));
        rd_x_q   <= (rd_x_q == X_LAST) ? '0 : rd_x_q + 1'b1;
      end
    end
  end
`else
  logic unused_test_mode;
  assign unused_test_mode = test_mode;
  assign READ_EN          = issue;
  assign push_data        = rd_data;
`endif

  fb_out_fifo #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q),
    .push_data (push_data),
    .pop       (pop),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  // Output raster position, advanced on each accepted pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
    end else if (pop) begin
      if (x_q == X_LAST) begin
        x_q <= '0;
        y_q <= (y_q == Y_LAST) ? '0 : y_q + 1'b1;
      end else begin
        x_q <= x_q + 1'b1;
      end
    end
  end

  assign m_data     = m_valid ? fifo_head : '0;
  assign m_sof      = m_valid && (x_q == '0) && (y_q == '0);
  assign m_eol      = m_valid && (x_q == X_LAST);
  assign frame_done = pop && (x_q == X_LAST) && (y_q == Y_LAST);

endmodule

// File: tb/tb_fb_scanout.sv
// Bench for fb_scanout with a 4x2 frame and a RAM holding data = address.
// When FB_SCANOUT_TEST_PATTERN_EN is defined, an 8x1 instance also checks the colour bars.
module tb_fb_scanout;

  localparam int AW = 3;
  localparam int DW = 15;
  localparam int H  = 4;
  localparam int V  = 2;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sof;
    logic          eol;
    logic          fd;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          test_mode;
  logic          READ_EN;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data = '0;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_sof;
  logic          m_eol;
  logic          frame_done;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_rd  = 0;
  int   n_acc = 0;
  int   max_out = 0;
  logic rand_rdy = 1'b0;

  always #5 clk = ~clk;

  fb_scanout #(
    .ADDRESS_WIDTH (AW),
    .DATA_WIDTH    (DW),
    .H_ACTIVE      (H),
    .V_ACTIVE      (V)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .test_mode  (test_mode),
    .READ_EN    (READ_EN),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_sof      (m_sof),
    .m_eol      (m_eol),
    .frame_done (frame_done)
  );

  // RAM model: one-cycle read latency, contents equal to the address.
  always @(posedge clk) begin
    if (READ_EN) rd_data <= DW'(rd_addr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_frame();
    exp_t e;
    for (int i = 0; i < H * V; i++) begin
      e.data = DW'(i);
      e.sof  = (i == 0);
      e.eol  = ((i % H) == H - 1);
      e.fd   = (i == H * V - 1);
      sb.push_back(e);
    end
  endtask

  task automatic wait_sb(input int n, input string name);
    int k;
    k = 0;
    while (sb.size() > n && k < 3000) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk(name, 32'(sb.size() <= n), 32'd1);
  endtask

  task automatic chk_idle_outputs(input string name);
    chk({name, "_read_en"}, 32'(READ_EN), 32'd0);
    chk({name, "_m_valid"}, 32'(m_valid), 32'd0);
  endtask

  // Monitor: compare every accepted pixel against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      n_rd  = 0;
      n_acc = 0;
    end else begin
      if (n_rd - n_acc > max_out) max_out = n_rd - n_acc;
      if (m_valid && m_ready) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_pixel: got data %0h with no pixel expected at %0t", m_data, $time);
        end else begin
          e = sb.pop_front();
          if ({m_data, m_sof, m_eol, frame_done} !== e) begin
            n_bad++;
            $display("FAIL pixel: got data=%0h sof=%0b eol=%0b fd=%0b expected data=%0h sof=%0b eol=%0b fd=%0b at %0t",
                     m_data, m_sof, m_eol, frame_done, e.data, e.sof, e.eol, e.fd, $time);
          end
        end
        n_acc++;
      end
      if (READ_EN) n_rd++;
    end
  end

  // Pseudo-random backpressure while enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) m_ready = ($urandom_range(0, 2) == 0);
    end
  end

`ifdef FB_SCANOUT_TEST_PATTERN_EN
  logic          en_tp;
  logic          READ_EN_tp;
  logic [AW-1:0] rd_addr_tp;
  logic [DW-1:0] m_data_tp;
  logic          m_valid_tp;
  logic          m_ready_tp;
  logic          m_sof_tp;
  logic          m_eol_tp;
  logic          frame_done_tp;
  logic [DW-1:0] rd_zero = '0;

  fb_scanout #(
    .ADDRESS_WIDTH (AW),
    .DATA_WIDTH    (DW),
    .H_ACTIVE      (8),
    .V_ACTIVE      (1)
  ) dut_tp (
    .clk        (clk),
    .rst        (rst),
    .en         (en_tp),
    .test_mode  (1'b1),
    .READ_EN    (READ_EN_tp),
    .rd_addr    (rd_addr_tp),
    .rd_data    (rd_zero),
    .m_data     (m_data_tp),
    .m_valid    (m_valid_tp),
    .m_ready    (m_ready_tp),
    .m_sof      (m_sof_tp),
    .m_eol      (m_eol_tp),
    .frame_done (frame_done_tp)
  );

  task automatic run_test_pattern();
    logic [DW-1:0] bars [8];
    int   k;
    logic rd_seen;
    bars[0] = 15'h7FFF; bars[1] = 15'h7FE0; bars[2] = 15'h03FF; bars[3] = 15'h03E0;
    bars[4] = 15'h7C1F; bars[5] = 15'h7C00; bars[6] = 15'h001F; bars[7] = 15'h0000;
    k       = 0;
    rd_seen = 1'b0;
    en_tp      = 1'b1;
    m_ready_tp = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (READ_EN_tp) rd_seen = 1'b1;
      if (m_valid_tp && m_ready_tp && k < 8) begin
        chk($sformatf("tp_bar%0d", k), 32'(m_data_tp), 32'(bars[k]));
        chk($sformatf("tp_eol%0d", k), 32'(m_eol_tp), 32'(k == 7));
        k++;
      end
      if (c == 2) en_tp = 1'b0;
    end
    chk("tp_pixel_count", 32'(k), 32'd8);
    chk("tp_read_en_low", 32'(rd_seen), 32'd0);
  endtask
`endif

  // Directed stimulus.
  initial begin
    int k;
    rst       = 1'b1;
    en        = 1'b0;
    test_mode = 1'b0;
    m_ready   = 1'b0;
`ifdef FB_SCANOUT_TEST_PATTERN_EN
    en_tp      = 1'b0;
    m_ready_tp = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_read_en", 32'(READ_EN), 32'd0);
    chk("rst_rd_addr", 32'(rd_addr), 32'd0);
    chk("rst_outputs", 32'({m_valid, m_sof, m_eol, frame_done}), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Full-throughput run: cycle 0 starts here.
    for (int f = 0; f < 7; f++) push_frame();
    en      = 1'b1;
    m_ready = 1'b1;
    @(negedge clk);
    chk("c0_read_en", 32'(READ_EN), 32'd0);
    chk("c0_m_valid", 32'(m_valid), 32'd0);
    @(negedge clk);
    chk("c1_read_en", 32'(READ_EN), 32'd1);
    chk("c1_rd_addr", 32'(rd_addr), 32'd0);
    @(negedge clk);
    chk("c2_m_valid", 32'(m_valid), 32'd0);
    chk("c2_rd_addr", 32'(rd_addr), 32'd1);
    @(negedge clk);
    chk("c3_m_valid", 32'(m_valid), 32'd1);
    chk("c3_m_data", 32'(m_data), 32'd0);
    chk("c3_m_sof", 32'(m_sof), 32'd1);
    for (int c = 4; c <= 18; c++) begin
      @(negedge clk);
      chk($sformatf("no_bubble_c%0d", c), 32'(m_valid), 32'd1);
    end

    // Random backpressure, then drop en while data 2 of the last frame is accepted.
    rand_rdy = 1'b1;
    wait_sb(5, "wait_data2");
    en = 1'b0;
    wait_sb(0, "drain_done");
    rand_rdy = 1'b0;
    #2;
    m_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk_idle_outputs("after_drain");
    chk("max_outstanding_le_2", 32'(max_out <= 2), 32'd1);

    // Reset with data 5 waiting at the head.
    @(posedge clk);
    #1;
    push_frame();
    en = 1'b1;
    k  = 0;
    while (!(m_valid && m_data == DW'(5)) && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("data5_pending", 32'(m_data), 32'd5);
    m_ready = 1'b0;
    rst     = 1'b1;
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_read_en", 32'(READ_EN), 32'd0);
    chk("post_rst_rd_addr", 32'(rd_addr), 32'd0);
    chk("post_rst_outputs", 32'({m_valid, m_sof, m_eol, frame_done}), 32'd0);
    chk("post_rst_m_data", 32'(m_data), 32'd0);
    @(posedge clk);
    #1;
    rst     = 1'b0;
    m_ready = 1'b1;
    push_frame();
    k = 0;
    while (!m_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("restart_data", 32'(m_data), 32'd0);
    chk("restart_sof", 32'(m_sof), 32'd1);
    #1;
    en = 1'b0;
    wait_sb(0, "restart_frame_done");
    repeat (4) @(negedge clk);
    chk_idle_outputs("final_idle");

`ifdef FB_SCANOUT_TEST_PATTERN_EN
    run_test_pattern();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fb_scanout.md
# fb_scanout

Frame-buffer scanout engine for the rainbow test path. It sits directly downstream of the frame-buffer `ram`: it issues raster-order reads on the RAM read port, absorbs the RAM's one-cycle read latency, and delivers pixels as a valid/ready stream with start-of-frame and end-of-line markers to the display/packing stage. It runs full-throughput (1 pixel/clk) under continuous `m_ready` and never drops or duplicates a pixel under backpressure.

## Interface
- `ADDRESS_WIDTH`, default 20: RAM address width; must satisfy 2**ADDRESS_WIDTH >= H_ACTIVE*V_ACTIVE.
- `DATA_WIDTH`, default 15: pixel width (RGB555), equal to the RAM data width.
- `H_ACTIVE`, default 640: pixels per line.
- `V_ACTIVE`, default 480: lines per frame.
---
- Clocking: one clock, `clk`; reset `rst` is synchronous and active-high.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous active-high reset.
- `en`  in  1  level; while high, frames stream back-to-back.
- `test_mode`  in  1  selects the generated colour bars (see Configuration).
- `READ_EN`  out  1  RAM read strobe.
- `rd_addr`  out  ADDRESS_WIDTH  RAM read address.
- `rd_data`  in  DATA_WIDTH  RAM `dout`, valid the cycle after `READ_EN`.
- `m_data`  out  DATA_WIDTH  pixel.
- `m_valid`  out  1  pixel valid.
- `m_ready`  in  1  consumer accept.
- `m_sof`  out  1  qualifies pixel (0,0).
- `m_eol`  out  1  qualifies the last pixel of each line.
- `frame_done`  out  1  one-cycle pulse when the last pixel of a frame is accepted.

## Operation
- States: IDLE, RUN, DRAIN.
  - IDLE -> RUN when `en`=1.
  - RUN -> DRAIN after the read for address FRAME_PIXELS-1 is issued and `en`=0; with `en`=1, RUN continues at address 0. Frames are never truncated.
  - DRAIN -> IDLE when the in-flight read and the buffer are both empty.
- Read issue: in RUN, `READ_EN`=1 iff (buffer occupancy + in-flight − pop this cycle) < 2. The read address counter increments per issued read and wraps from FRAME_PIXELS-1 to 0.
- Capture: the in-flight flag is set on issue. The cycle after, `rd_data` is pushed into the 2-entry buffer.
- Output: buffer head drives `m_data`. A pop occurs on `m_valid && m_ready`.
  - Output x/y counters advance on each pop.
  - `m_sof` = (x==0 && y==0); `m_eol` = (x==H_ACTIVE-1).
- Holding: `m_data`, `m_sof` and `m_eol` stay stable while `m_valid && !m_ready`.
- Reset values: all outputs 0, state IDLE, counters 0, buffer empty, in-flight cleared. Reset mid-frame discards the in-flight read, and the next frame restarts at address 0 with `m_sof`.

## Timing
- `en` sampled high in IDLE at cycle 0 -> RUN, `READ_EN`=1 and `rd_addr`=0 in cycle 1 -> `m_valid`=1 in cycle 3.
- With `m_ready` held high, one pixel per cycle, no bubbles, including across the frame wrap.
- When `m_ready` drops, at most one further read issues. The buffer never overflows.
- `frame_done` asserts in the same cycle as the accepted `m_eol` on line V_ACTIVE-1.

## Configuration
- Macro: `FB_SCANOUT_TEST_PATTERN_EN`.
- Defined, `test_mode`=1 (sampled at frame start only):
  - `READ_EN` is held 0.
  - Pixels are generated internally as 8 vertical colour bars of width H_ACTIVE/8, in the order white, yellow, cyan, green, magenta, red, blue, black in RGB555.
  - Handshake, latency and markers are identical to RAM mode.
- Not defined: `test_mode` is ignored, and no generator logic is present.

## Structure
- `fb_pkg` holds:
  - `pixel_t` (DATA_WIDTH logic vector);
  - the state enum `scan_state_t`;
  - `FRAME_PIXELS` = H_ACTIVE*V_ACTIVE;
  - the RGB555 colour-bar constants.
- Sub-module `fb_out_fifo`: a 2-entry buffer with push, pop, `count` and head data.

## Test plan
Bench parameters: H_ACTIVE=4, V_ACTIVE=2, RAM preloaded with data = address.
- `en`=1 and `m_ready`=1 from cycle 0:
  - `m_data` = 0,1,…,7 on cycles 3–10, one per cycle.
  - `m_sof` on data 0; `m_eol` on data 3 and 7; `frame_done` at data 7.
  - Data 0 follows data 7 directly, with no gap.
- `m_ready` toggles 1,0,0,1,… (pseudo-random): the accepted sequence is exactly 0..7 repeating, and no more than 2 reads are outstanding relative to accepts.
- `en` drops while data 2 is being accepted: the frame completes through data 7, then the block goes to IDLE with `READ_EN`=0 and `m_valid`=0.
- `rst` pulsed with data 5 pending: all outputs are 0 the next cycle. With `en`=1 after release, the first accepted pixel is data 0 with `m_sof`=1.
- `FB_SCANOUT_TEST_PATTERN_EN` defined, `test_mode`=1, H_ACTIVE=8: `READ_EN` stays 0 and line pixels are the 8 bar colours, white first, black last with `m_eol`.
